// File: rtl/hilo_muldiv_if.sv
// HI/LO multiply/divide sequencer bus: op issue and operands from decode,
// MFHI/MFLO hazard inputs, and the HI/LO/status outputs back to the core.
interface hilo_muldiv_if;
  logic        start_i;
  logic [5:0]  funct_i;
  logic [31:0] rs_i;
  logic [31:0] rt_i;
  logic        read_hi_i;
  logic        read_lo_i;
  logic        busy_o;
  logic        stall_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  // Decode/pipeline side
  modport master (
    output start_i, funct_i, rs_i, rt_i, read_hi_i, read_lo_i,
    input  busy_o, stall_o, done_o, hi_o, lo_o
  );

  // Sequencer side
  modport slave (
    input  start_i, funct_i, rs_i, rt_i, read_hi_i, read_lo_i,
    output busy_o, stall_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register owner: registered multiplier (MUL_LATENCY edges) and a
// 32-step restoring divider with a final sign-fixup state.
// Optional macro HILO_DIV_EARLY_OUT_EN: skip the iteration loop when the
// dividend magnitude is below the divisor magnitude.
module hilo_muldiv_ctrl #(
  parameter int unsigned MUL_LATENCY = 2,
  parameter int unsigned DIV_BITS    = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  hilo_muldiv_if.slave    bus
);

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 6;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_WAIT = 2'd1,
    S_DIV_ITER = 2'd2,
    S_DIV_SIGN = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2*W-1:0]   prod_q, prod_d;
  logic [W-1:0]     quot_q, quot_d;
  logic [W-1:0]     rem_q, rem_d;
  logic [W-1:0]     dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;

  logic             is_sdiv;
  logic             rs_neg, rt_neg;
  logic [W-1:0]     rs_mag, rt_mag;
  logic [2*W-1:0]   mul_s, mul_u;
  logic [W:0]       shift_rem;
  logic [W:0]       trial;

  // Operand conditioning: magnitudes for DIV, 64-bit products, trial subtract
  always_comb begin
    is_sdiv   = (bus.funct_i == F_DIV);
    rs_neg    = is_sdiv & bus.rs_i[W-1];
    rt_neg    = is_sdiv & bus.rt_i[W-1];
    rs_mag    = rs_neg ? (~bus.rs_i + W'(1)) : bus.rs_i;
    rt_mag    = rt_neg ? (~bus.rt_i + W'(1)) : bus.rt_i;
    mul_s     = {{W{bus.rs_i[W-1]}}, bus.rs_i} * {{W{bus.rt_i[W-1]}}, bus.rt_i};
    mul_u     = {{W{1'b0}}, bus.rs_i} * {{W{1'b0}}, bus.rt_i};
    shift_rem = {rem_q, quot_q[W-1]};
    trial     = shift_rem - {1'b0, dvs_q};
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    prod_d  = prod_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          case (bus.funct_i)
            F_MTHI: begin
              hi_d   = bus.rs_i;
              done_d = 1'b1;
            end
            F_MTLO: begin
              lo_d   = bus.rs_i;
              done_d = 1'b1;
            end
            F_MULT, F_MULTU: begin
              prod_d  = (bus.funct_i == F_MULT) ? mul_s : mul_u;
              cnt_d   = CNT_W'(MUL_LATENCY - 1);
              state_d = S_MUL_WAIT;
            end
            F_DIV, F_DIVU: begin
              dvs_d  = rt_mag;
              qneg_d = rs_neg ^ rt_neg;
              rneg_d = rs_neg;
              if (bus.rt_i == '0) begin
                // Divide by zero: commit zeros from the sign state
                quot_d  = '0;
                rem_d   = '0;
                qneg_d  = 1'b0;
                rneg_d  = 1'b0;
                state_d = S_DIV_SIGN;
              end
`ifdef HILO_DIV_EARLY_OUT_EN
              else if (rs_mag < rt_mag) begin
                // Quotient is zero; sign fixup restores the original rs
                quot_d  = '0;
                rem_d   = rs_mag;
                state_d = S_DIV_SIGN;
              end
`endif
              else begin
                quot_d  = rs_mag;
                rem_d   = '0;
                cnt_d   = CNT_W'(DIV_BITS - 1);
                state_d = S_DIV_ITER;
              end
            end
            default: ;
          endcase
        end
      end

      S_MUL_WAIT: begin
        if (cnt_q == '0) begin
          hi_d    = prod_q[2*W-1:W];
          lo_d    = prod_q[W-1:0];
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_DIV_ITER: begin
        // One restoring step; quotient bits shift in as dividend bits shift out
        if (!trial[W]) begin
          rem_d  = trial[W-1:0];
          quot_d = {quot_q[W-2:0], 1'b1};
        end else begin
          rem_d  = shift_rem[W-1:0];
          quot_d = {quot_q[W-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = S_DIV_SIGN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_DIV_SIGN: begin
        lo_d    = qneg_q ? (~quot_q + W'(1)) : quot_q;
        hi_d    = rneg_q ? (~rem_q + W'(1)) : rem_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      prod_q  <= prod_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;
  assign bus.stall_o = busy_q & (bus.read_hi_i | bus.read_lo_i | bus.start_i);

endmodule
